cordic_vector: RTL and testbench

CORDIC_VECTOR -- requirements
Module: cordic_vector

---
 rtl/cordic_pkg.sv | 27 ++
 rtl/cordic_atan_rom.sv | 11 +
 rtl/cordic_vector.sv | 131 +++++++++++++
 tb/tb_cordic_vector.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM states, quadrant angles and the arctangent table
// (binary angle units, 2^32 = one full turn).
package cordic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRE,
      ST_ITER,
      ST_DONE
   } state_t;

   localparam logic [31:0] ANG_90  = 32'h4000_0000;
   localparam logic [31:0] ANG_M90 = 32'hC000_0000;

   // atan(2^-i) scaled so that 2^32 is one full turn, rounded to nearest
   localparam logic [31:0] ATAN_TAB [32] = '{
      32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
      32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
      32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
      32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
      32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
      32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
      32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
      32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
   };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, shared by the vectoring and rotation CORDICs.
module cordic_atan_rom
   import cordic_pkg::*;
(
   input  logic [4:0]  idx,
   output logic [31:0] angle
);

   assign angle = ATAN_TAB[idx];

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts (x, y) to angle = atan2(y, x) and an
// uncompensated magnitude (gain K ~ 1.6468), one micro-rotation per clock.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; inputs captured on an accepted start
// PRE     | fold left half-plane onto the right, flag zero vector
// ITER    | one micro-rotation per cycle, i = 0..ITER-1; results latched on last
// DONE    | done pulse, results valid; start ignored
module cordic_vector
   import cordic_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITER  = 30
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] y_in,
   output logic [31:0]      angle_out,
   output logic [WIDTH:0]   mag_out,
   output logic             busy,
   output logic             done
);

   localparam int         W2   = WIDTH + 2;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   state_t               state, state_nxt;
   logic signed [W2-1:0] x_q, y_q, x_sh, y_sh, x_step, y_step;
   logic [31:0]          z_q, z_step, atan_i;
   logic [4:0]           cnt;
   logic                 zero_q;

   cordic_atan_rom u_rom (
      .idx   (cnt),
      .angle (atan_i)
   );

   // Both updates use the pre-step x/y values.
   always_comb begin
      x_sh = x_q >>> cnt;
      y_sh = y_q >>> cnt;
      if (!y_q[W2-1]) begin
         x_step = x_q + y_sh;
         y_step = y_q - x_sh;
         z_step = z_q + atan_i;
      end else begin
         x_step = x_q - y_sh;
         y_step = y_q + x_sh;
         z_step = z_q - atan_i;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_PRE;
         ST_PRE: begin
            busy      = 1'b1;
            state_nxt = ST_ITER;
         end
         ST_ITER: begin
            busy = 1'b1;
            if (cnt == LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         x_q       <= '0;
         y_q       <= '0;
         z_q       <= '0;
         zero_q    <= 1'b0;
         angle_out <= '0;
         mag_out   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  x_q <= {{2{x_in[WIDTH-1]}}, x_in};
                  y_q <= {{2{y_in[WIDTH-1]}}, y_in};
                  cnt <= '0;
               end
            end
            ST_PRE: begin
               zero_q <= (x_q == '0) && (y_q == '0);
               cnt    <= '0;
               // Rotate by +/-90 deg so the CORDIC only has to cover the right half-plane.
               if (x_q[W2-1] && !y_q[W2-1]) begin
                  x_q <= y_q;
                  y_q <= -x_q;
                  z_q <= ANG_90;
               end else if (x_q[W2-1]) begin
                  x_q <= -y_q;
                  y_q <= x_q;
                  z_q <= ANG_M90;
               end else begin
                  z_q <= '0;
               end
            end
            ST_ITER: begin
               x_q <= x_step;
               y_q <= y_step;
               z_q <= z_step;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  angle_out <= zero_q ? '0 : z_step;
                  mag_out   <= zero_q ? '0 : x_step[WIDTH:0];
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed vectors, randomized vectors
// against a floating-point atan2/hypot model, and control-timing scenarios.
module tb_cordic_vector;

   localparam int  WIDTH  = 32;
   localparam int  ITER   = 30;
   localparam int  LAT    = ITER + 2;
   localparam int  TOL    = ITER + 2;
   localparam real KGAIN  = 1.6467602581;
   localparam real TWO_PI = 6.283185307179586;

   logic               clk   = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic [WIDTH-1:0]   x_in  = '0;
   logic [WIDTH-1:0]   y_in  = '0;
   logic [31:0]        angle_out;
   logic [WIDTH:0]     mag_out;
   logic               busy;
   logic               done;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   cordic_vector #(.WIDTH(WIDTH), .ITER(ITER)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .x_in      (x_in),
      .y_in      (y_in),
      .angle_out (angle_out),
      .mag_out   (mag_out),
      .busy      (busy),
      .done      (done)
   );

   function automatic logic [31:0] ref_angle(input logic [31:0] xv, input logic [31:0] yv);
      real    a;
      longint r;
      longint xs, ys;
      xs = longint'($signed(xv));
      ys = longint'($signed(yv));
      if (xs == 0 && ys == 0) return 32'h0;
      a = $atan2(real'(ys), real'(xs));
      if (a < 0.0) a = a + TWO_PI;
      r = longint'(a * 4294967296.0 / TWO_PI);
      return r[31:0];
   endfunction

   function automatic real ref_mag(input logic [31:0] xv, input logic [31:0] yv);
      real xr, yr;
      xr = real'(longint'($signed(xv)));
      yr = real'(longint'($signed(yv)));
      return KGAIN * $sqrt(xr * xr + yr * yr);
   endfunction

   function automatic int ang_err(input logic [31:0] got, input logic [31:0] want);
      logic [31:0] d;
      int          e;
      d = got - want;
      e = int'($signed(d));
      return (e < 0) ? -e : e;
   endfunction

   function automatic real mag_err(input logic [WIDTH:0] got, input real want);
      real g;
      g = real'({31'b0, got});
      return (g > want) ? g - want : want - g;
   endfunction

   // Stimulus driver: launches one conversion, optionally re-pulses start with other
   // data at cycle 'repulse', and records the first done cycle and its results.
   task automatic do_conv(input logic [31:0] xv, input logic [31:0] yv,
                          input int repulse, input logic [31:0] rx, input logic [31:0] ry,
                          output logic [31:0] ang, output logic [WIDTH:0] mag,
                          output int lat, output int ndone, output logic busy1);
      @(negedge clk);
      x_in  = xv;
      y_in  = yv;
      start = 1'b1;
      @(posedge clk);
      lat   = -1;
      ndone = 0;
      ang   = '0;
      mag   = '0;
      busy1 = 1'b0;
      for (int k = 1; k <= LAT + 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 1) busy1 = busy;
         if (repulse != 0 && k == repulse) begin
            x_in  = rx;
            y_in  = ry;
            start = 1'b1;
         end
         if (done) begin
            ndone++;
            if (lat < 0) begin
               lat = k;
               ang = angle_out;
               mag = mag_out;
            end
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (angle_out !== 32'h0) $display("FAIL reset_angle: got %h want 00000000", angle_out);
      else n_pass++;
      n_checks++;
      if (mag_out !== '0) $display("FAIL reset_mag: got %h want 0", mag_out);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else n_pass++;
      n_checks++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
      else n_pass++;
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] xs [5] = '{32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'hC000_0000, 32'h8000_0000};
      logic [31:0] ys [5] = '{32'h0000_0000, 32'h4000_0000, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000};
      logic [31:0] ea [5] = '{32'h0000_0000, 32'h2000_0000, 32'h4000_0000, 32'hA000_0000, 32'h8000_0000};
      real         em [5] = '{1768195363.0, 2500605859.0, 1768195363.0, 2500605859.0, 3536390726.0};
      logic [31:0]    ang;
      logic [WIDTH:0] mag;
      int             lat, nd;
      logic           b1;
      for (int i = 0; i < 5; i++) begin
         do_conv(xs[i], ys[i], 0, '0, '0, ang, mag, lat, nd, b1);
         n_checks++;
         if (lat != LAT) $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, LAT);
         else n_pass++;
         n_checks++;
         if (nd != 1) $display("FAIL dir_done_count[%0d]: got %0d want 1", i, nd);
         else n_pass++;
         n_checks++;
         if (b1 !== 1'b1) $display("FAIL dir_busy[%0d]: got %b want 1", i, b1);
         else n_pass++;
         n_checks++;
         if (ang_err(ang, ea[i]) > TOL) $display("FAIL dir_angle[%0d]: got %h want %h", i, ang, ea[i]);
         else n_pass++;
         n_checks++;
         if (mag_err(mag, em[i]) > real'(TOL)) $display("FAIL dir_mag[%0d]: got %0d want %0.1f", i, mag, em[i]);
         else n_pass++;
      end
   endtask

   task automatic test_zero();
      logic [31:0]    ang;
      logic [WIDTH:0] mag;
      int             lat, nd;
      logic           b1;
      do_conv(32'h0, 32'h0, 0, '0, '0, ang, mag, lat, nd, b1);
      n_checks++;
      if (lat != LAT) $display("FAIL zero_latency: got %0d want %0d", lat, LAT);
      else n_pass++;
      n_checks++;
      if (ang !== 32'h0) $display("FAIL zero_angle: got %h want 00000000", ang);
      else n_pass++;
      n_checks++;
      if (mag !== '0) $display("FAIL zero_mag: got %h want 0", mag);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [31:0]    xv, yv, ang;
      logic [WIDTH:0] mag;
      int             lat, nd, tries;
      logic           b1;
      for (int n = 0; n < 24; n++) begin
         tries = 0;
         do begin
            xv = $urandom;
            yv = $urandom;
            tries++;
         end while (tries < 100 && ref_mag(xv, yv) < KGAIN * 1073741824.0);
         do_conv(xv, yv, 0, '0, '0, ang, mag, lat, nd, b1);
         n_checks++;
         if (ang_err(ang, ref_angle(xv, yv)) > TOL)
            $display("FAIL rnd_angle[%0d] x=%h y=%h: got %h want %h", n, xv, yv, ang, ref_angle(xv, yv));
         else n_pass++;
         n_checks++;
         if (mag_err(mag, ref_mag(xv, yv)) > real'(TOL))
            $display("FAIL rnd_mag[%0d] x=%h y=%h: got %0d want %0.1f", n, xv, yv, mag, ref_mag(xv, yv));
         else n_pass++;
      end
   endtask

   task automatic test_repulse();
      logic [31:0]    ang;
      logic [WIDTH:0] mag;
      int             lat, nd;
      logic           b1;
      do_conv(32'h4000_0000, 32'h4000_0000, 5, 32'hC000_0000, 32'h0, ang, mag, lat, nd, b1);
      n_checks++;
      if (nd != 1) $display("FAIL repulse_done_count: got %0d want 1", nd);
      else n_pass++;
      n_checks++;
      if (lat != LAT) $display("FAIL repulse_latency: got %0d want %0d", lat, LAT);
      else n_pass++;
      n_checks++;
      if (ang_err(ang, 32'h2000_0000) > TOL) $display("FAIL repulse_angle: got %h want 20000000", ang);
      else n_pass++;
      n_checks++;
      if (mag_err(mag, 2500605859.0) > real'(TOL)) $display("FAIL repulse_mag: got %0d want 2500605859", mag);
      else n_pass++;
   endtask

   // Start held across the done cycle: ignored while done is high, accepted on the next edge.
   task automatic test_back_to_back();
      logic [31:0]    xa, ya, xb, yb, ang_a;
      logic [WIDTH:0] mag_a;
      int             k, j;
      logic           seen;
      xa = 32'h3000_0000; ya = 32'h1000_0000;
      xb = 32'hD000_0000; yb = 32'hE000_0000;
      @(negedge clk);
      x_in = xa; y_in = ya; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      k = 1;
      while (!done && k < LAT + 8) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k != LAT || !done) $display("FAIL b2b_first_latency: got %0d want %0d", k, LAT);
      else n_pass++;
      ang_a = angle_out;
      mag_a = mag_out;
      x_in = xb; y_in = yb; start = 1'b1;
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_start_in_done: got busy=%b done=%b want busy=0 done=0", busy, done);
      else n_pass++;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy);
      else n_pass++;
      seen = 1'b0;
      j = 1;
      while (!done && j < LAT + 8) begin
         if (angle_out !== ang_a || mag_out !== mag_a) seen = 1'b1;
         @(negedge clk);
         j++;
      end
      n_checks++;
      if (seen) $display("FAIL b2b_hold: got output change before done want held %h/%0d", ang_a, mag_a);
      else n_pass++;
      n_checks++;
      if (j != LAT || !done) $display("FAIL b2b_second_latency: got %0d want %0d", j, LAT);
      else n_pass++;
      n_checks++;
      if (ang_err(ang_a, ref_angle(xa, ya)) > TOL) $display("FAIL b2b_angle_a: got %h want %h", ang_a, ref_angle(xa, ya));
      else n_pass++;
      n_checks++;
      if (ang_err(angle_out, ref_angle(xb, yb)) > TOL) $display("FAIL b2b_angle_b: got %h want %h", angle_out, ref_angle(xb, yb));
      else n_pass++;
      n_checks++;
      if (mag_err(mag_out, ref_mag(xb, yb)) > real'(TOL)) $display("FAIL b2b_mag_b: got %0d want %0.1f", mag_out, ref_mag(xb, yb));
      else n_pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [31:0] xv, yv;
      int          stray, k;
      xv = 32'h4000_0000; yv = 32'h2000_0000;
      @(negedge clk);
      x_in = 32'h1000_0000; y_in = 32'h7000_0000; start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if (angle_out !== 32'h0 || mag_out !== '0) $display("FAIL midrst_outputs: got %h/%h want 0/0", angle_out, mag_out);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrst_flags: got busy=%b done=%b want 0/0", busy, done);
      else n_pass++;
      reset = 1'b1;
      x_in = xv; y_in = yv; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1) $display("FAIL midrst_accept: got busy=%b want 1", busy);
      else n_pass++;
      stray = 0;
      k = 1;
      while (!done && k < LAT + 8) begin
         @(negedge clk);
         k++;
         if (done && k != LAT) stray++;
      end
      n_checks++;
      if (stray != 0 || k != LAT) $display("FAIL midrst_done_timing: got done at %0d (stray %0d) want %0d", k, stray, LAT);
      else n_pass++;
      n_checks++;
      if (ang_err(angle_out, ref_angle(xv, yv)) > TOL) $display("FAIL midrst_angle: got %h want %h", angle_out, ref_angle(xv, yv));
      else n_pass++;
      n_checks++;
      if (mag_err(mag_out, ref_mag(xv, yv)) > real'(TOL)) $display("FAIL midrst_mag: got %0d want %0.1f", mag_out, ref_mag(xv, yv));
      else n_pass++;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_directed();
      test_zero();
      test_random();
      test_repulse();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
